// File: rtl/circle_path_ctrl.sv
// circle_path_ctrl
// Animation sequencer that walks one "circle" around a row of 7-seg digits.
// The upper row is traversed left-to-right and the lower row right-to-left.
// The outputs drive a bank of circle_on_seg encoders: en[i] selects digit i,
// and row is shared by all digits. Every output comes straight from a flop.

module circle_path_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000,
    localparam int POS_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  blank,
    output logic                  row,
    output logic [NUM_DIGITS-1:0] en,
    output logic [POS_W-1:0]      pos,
    output logic                  step
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    logic [CNT_W-1:0]      cnt_q,  cnt_d;
    logic [POS_W-1:0]      pos_q,  pos_d;
    logic                  row_q,  row_d;
    logic                  step_q, step_d;
    logic [NUM_DIGITS-1:0] en_q,   en_d;
    logic                  tick;

    // Prescaler, path walk and enable decode for the next clock edge.
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        row_d  = row_q;
        step_d = 1'b0;
        en_d   = '0;
        tick   = run && (cnt_q == CNT_LAST);

        // The count only moves while running, so a pause resumes mid-interval.
        if (run) begin
            if (tick) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // The path is a ring of 2*NUM_DIGITS states; the ends of each row
        // turn the circle onto the other row instead of wrapping pos.
        if (tick) begin
            step_d = 1'b1;
            if (dir) begin
                if (row_q) begin
                    if (pos_q == POS_LAST) begin
                        row_d = 1'b0;
                    end else begin
                        pos_d = pos_q + POS_ONE;
                    end
                end else begin
                    if (pos_q == '0) begin
                        row_d = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                end
            end else begin
                if (row_q) begin
                    if (pos_q == '0) begin
                        row_d = 1'b0;
                    end else begin
                        pos_d = pos_q - POS_ONE;
                    end
                end else begin
                    if (pos_q == POS_LAST) begin
                        row_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_ONE;
                    end
                end
            end
        end

        // Enable follows the position being loaded this edge unless blanked.
        if (!blank) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                en_d[i] = (pos_d == POS_W'(i));
            end
        end
    end

    // State registers with synchronous active-low reset to the top-left digit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            row_q  <= 1'b1;
            step_q <= 1'b0;
            en_q   <= NUM_DIGITS'(1);
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            row_q  <= row_d;
            step_q <= step_d;
            en_q   <= en_d;
        end
    end

    assign row  = row_q;
    assign en   = en_q;
    assign pos  = pos_q;
    assign step = step_q;

endmodule

// File: tb/tb_circle_path_ctrl.sv
// tb_circle_path_ctrl
// Directed bench for circle_path_ctrl with four digits and a four-cycle step.
// Expected path states are written out by hand for each phase.

module tb_circle_path_ctrl;

    localparam int ND = 4;
    localparam int TD = 4;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          dir;
    logic          blank;
    logic          row;
    logic [ND-1:0] en;
    logic [1:0]    pos;
    logic          step;

    int total;
    int bad;

    circle_path_ctrl #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (run),
        .dir  (dir),
        .blank(blank),
        .row  (row),
        .en   (en),
        .pos  (pos),
        .step (step)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Wait pre quiet cycles, then expect a step into the given state.
    task automatic doStep(input string tag, input int pre, input logic [1:0] ePos,
                          input logic eRow, input logic [3:0] eEn);
        for (int i = 0; i < pre; i++) begin
            applyStimulus();
            checkOutput({tag, "_quiet"}, 32'(step), 32'd0);
        end
        applyStimulus();
        checkOutput({tag, "_step"}, 32'(step), 32'd1);
        checkOutput({tag, "_pos"},  32'(pos),  32'(ePos));
        checkOutput({tag, "_row"},  32'(row),  32'(eRow));
        checkOutput({tag, "_en"},   32'(en),   32'(eEn));
    endtask

    logic [1:0] fwdPos [8] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
    logic       fwdRow [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] fwdEn  [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
    logic [1:0] revPos [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    logic       revRow [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [3:0] revEn  [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        dir   = 1'b1;
        blank = 1'b0;

        // Reset state
        applyStimulus();
        applyStimulus();
        checkOutput("rst_row",  32'(row),  32'd1);
        checkOutput("rst_en",   32'(en),   32'b0001);
        checkOutput("rst_pos",  32'(pos),  32'd0);
        checkOutput("rst_step", 32'(step), 32'd0);

        // Forward lap, first step TICK_DIV cycles after run rises
        $display("[TB] forward lap");
        rst_n = 1'b1;
        run   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            doStep($sformatf("fwd%0d", k), TD - 1, fwdPos[k], fwdRow[k], fwdEn[k]);
        end

        // Reverse lap from a fresh reset
        $display("[TB] reverse lap");
        rst_n = 1'b0;
        run   = 1'b0;
        applyStimulus();
        applyStimulus();
        rst_n = 1'b1;
        run   = 1'b1;
        dir   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            doStep($sformatf("rev%0d", k), TD - 1, revPos[k], revRow[k], revEn[k]);
        end
        doStep("rev8", TD - 1, 2'd0, 1'b0, 4'b0001);
        doStep("rev9", TD - 1, 2'd1, 1'b0, 4'b0010);

        // Direction flip mid-interval: from (1,0) forward goes to (0,0)
        applyStimulus();
        applyStimulus();
        dir = 1'b1;
        doStep("flip", 1, 2'd0, 1'b0, 4'b0001);
        doStep("flip2", TD - 1, 2'd0, 1'b1, 4'b0001);

        // Pause at cnt=2 for ten cycles, then step two cycles after resuming
        $display("[TB] pause");
        applyStimulus();
        applyStimulus();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("pause_step", 32'(step), 32'd0);
        end
        checkOutput("pause_pos", 32'(pos), 32'd0);
        checkOutput("pause_row", 32'(row), 32'd1);
        checkOutput("pause_en",  32'(en),  32'b0001);
        run = 1'b1;
        doStep("resume", 1, 2'd1, 1'b1, 4'b0010);

        // Blanking clears enables next cycle while the walk carries on
        $display("[TB] blank");
        blank = 1'b1;
        applyStimulus();
        checkOutput("blank_en", 32'(en), 32'b0000);
        doStep("blank_walk", TD - 2, 2'd2, 1'b1, 4'b0000);
        blank = 1'b0;
        applyStimulus();
        checkOutput("unblank_en", 32'(en), 32'b0100);
        doStep("unblank1", TD - 2, 2'd3, 1'b1, 4'b1000);
        doStep("unblank2", TD - 1, 2'd3, 1'b0, 4'b1000);
        doStep("unblank3", TD - 1, 2'd2, 1'b0, 4'b0100);

        // Reset in the middle of a lap while running
        $display("[TB] mid-lap reset");
        applyStimulus();
        rst_n = 1'b0;
        applyStimulus();
        checkOutput("mrst_row",  32'(row),  32'd1);
        checkOutput("mrst_pos",  32'(pos),  32'd0);
        checkOutput("mrst_en",   32'(en),   32'b0001);
        checkOutput("mrst_step", 32'(step), 32'd0);
        rst_n = 1'b1;
        doStep("after_rst", TD - 1, 2'd1, 1'b1, 4'b0010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
